// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch stage: PC, imem request/grant/response handshake,
// and a registered instruction presented downstream via valid/ready. Optional FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]           NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clock,
  input  logic                  resetN,
  output logic                  imemReq,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  input  logic                  imemGrant,
  input  logic                  imemRspValid,
  input  logic [31:0]           imemRspData,
  output logic                  instrValid,
  input  logic                  instrReady,
  output logic [31:0]           instruction,
  output logic [6:0]            opcode,
  output logic [ADDR_WIDTH-1:0] instrPc,
  input  logic                  branchTaken,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  output logic                  fetchFault
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
    , FAULT
`endif
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] instr_pc_q;
  logic [31:0]           instr_q;
  logic                  valid_q;
  logic                  req_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic                  fault_q;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (imemGrant) begin
            state <= WAIT;
            req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (imemRspValid) begin
            instr_q    <= imemRspData;
            instr_pc_q <= pc;
            valid_q    <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (instrReady) begin
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (branchTaken && (branchTarget[1:0] != 2'b00)) begin
              fault_q <= 1'b1;
              state   <= FAULT;
            end else begin
              pc    <= branchTaken ? branchTarget : pc + PC_STEP;
              req_q <= 1'b1;
              state <= FETCH;
            end
`else
            // Redirect targets are silently word-aligned when trapping is disabled.
            pc    <= branchTaken ? (branchTarget & ALIGN_MASK) : pc + PC_STEP;
            req_q <= 1'b1;
            state <= FETCH;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        FAULT: begin
          state <= FAULT;
        end
`endif
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imemReq     = req_q;
  assign imemAddr    = pc;
  assign instrValid  = valid_q;
  assign instruction = instr_q;
  assign opcode      = instr_q[6:0];
  assign instrPc     = instr_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetchFault  = fault_q;
`else
  assign fetchFault  = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed handshake scenarios plus a
// randomized run checked against a transaction-level PC/instruction model.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        resetN;
  logic        imemGrant, imemRspValid, instrReady, branchTaken;
  logic [31:0] imemRspData;
  logic [63:0] branchTarget;

  logic        imemReq, instrValid, fetchFault;
  logic [63:0] imemAddr, instrPc;
  logic [31:0] instruction;
  logic [6:0]  opcode;

  logic        hi_imemReq, hi_instrValid, hi_fetchFault;
  logic [63:0] hi_imemAddr, hi_instrPc;
  logic [31:0] hi_instruction;
  logic [6:0]  hi_opcode;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  instruction_fetch_unit #(.ADDR_WIDTH(64), .RESET_PC(64'h0), .NOP_INSTR(32'h0000_0013)) dut (
    .clock(clock), .resetN(resetN), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemGrant(imemGrant), .imemRspValid(imemRspValid), .imemRspData(imemRspData),
    .instrValid(instrValid), .instrReady(instrReady), .instruction(instruction),
    .opcode(opcode), .instrPc(instrPc), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .fetchFault(fetchFault)
  );

  // Second instance sits at the top of the address space to exercise PC wrap.
  instruction_fetch_unit #(.ADDR_WIDTH(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .NOP_INSTR(32'h0000_0013)) dut_hi (
    .clock(clock), .resetN(resetN), .imemReq(hi_imemReq), .imemAddr(hi_imemAddr),
    .imemGrant(imemGrant), .imemRspValid(imemRspValid), .imemRspData(imemRspData),
    .instrValid(hi_instrValid), .instrReady(instrReady), .instruction(hi_instruction),
    .opcode(hi_opcode), .instrPc(hi_instrPc), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .fetchFault(hi_fetchFault)
  );

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    imemGrant = 1'b0; imemRspValid = 1'b0; imemRspData = '0;
    instrReady = 1'b0; branchTaken = 1'b0; branchTarget = '0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    idle_inputs();
    cyc(); cyc();
    compared++;
    if (imemReq !== 1'b0 || instrValid !== 1'b0 || fetchFault !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: req=%b valid=%b fault=%b expected 0/0/0", imemReq, instrValid, fetchFault);
    end
    compared++;
    if (instruction !== 32'h0000_0013 || opcode !== 7'h13 || instrPc !== 64'h0) begin
      mismatched++;
      $display("FAIL reset_data: instr=%h op=%h pc=%h expected 00000013/13/0", instruction, opcode, instrPc);
    end
    compared++;
    if (hi_instrPc !== 64'hFFFF_FFFF_FFFF_FFFC || hi_imemAddr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      mismatched++;
      $display("FAIL reset_hi_pc: instrPc=%h addr=%h expected fffffffffffffffc", hi_instrPc, hi_imemAddr);
    end
    resetN = 1'b1;
  endtask

  task automatic test_basic();
    cyc();
    compared++;
    if (imemReq !== 1'b1 || imemAddr !== 64'h0) begin
      mismatched++;
      $display("FAIL basic_req0: req=%b addr=%h expected 1/0", imemReq, imemAddr);
    end
    imemGrant = 1'b1; cyc(); imemGrant = 1'b0;
    compared++;
    if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_wait: req=%b valid=%b expected 0/0", imemReq, instrValid);
    end
    imemRspValid = 1'b1; imemRspData = 32'h00A0_0093; cyc(); imemRspValid = 1'b0;
    compared++;
    if (instrValid !== 1'b1 || opcode !== 7'h13 || instruction !== 32'h00A0_0093 || instrPc !== 64'h0) begin
      mismatched++;
      $display("FAIL basic_present: valid=%b op=%h instr=%h pc=%h expected 1/13/00a00093/0",
               instrValid, opcode, instruction, instrPc);
    end
    instrReady = 1'b1; cyc(); instrReady = 1'b0;
    compared++;
    if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 64'h4) begin
      mismatched++;
      $display("FAIL basic_next: valid=%b req=%b addr=%h expected 0/1/4", instrValid, imemReq, imemAddr);
    end
    compared++;
    if (hi_imemReq !== 1'b1 || hi_imemAddr !== 64'h0 || hi_instrPc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      mismatched++;
      $display("FAIL pc_wrap: req=%b addr=%h instrPc=%h expected 1/0/fffffffffffffffc",
               hi_imemReq, hi_imemAddr, hi_instrPc);
    end
  endtask

  task automatic test_grant_stall();
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (imemReq !== 1'b1 || imemAddr !== 64'h4) begin
        mismatched++;
        $display("FAIL stall_req[%0d]: req=%b addr=%h expected 1/4", i, imemReq, imemAddr);
      end
      if (i < 3) cyc();
    end
    imemGrant = 1'b1; cyc(); imemGrant = 1'b0;
    cyc();
    compared++;
    if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_wait: req=%b valid=%b expected 0/0", imemReq, instrValid);
    end
    imemRspValid = 1'b1; imemRspData = 32'h0020_81B3; cyc(); imemRspValid = 1'b0;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (instrValid !== 1'b1 || opcode !== 7'h33 || instruction !== 32'h0020_81B3 ||
          instrPc !== 64'h4 || imemReq !== 1'b0) begin
        mismatched++;
        $display("FAIL hold[%0d]: valid=%b op=%h instr=%h pc=%h req=%b expected 1/33/002081b3/4/0",
                 i, instrValid, opcode, instruction, instrPc, imemReq);
      end
      imemRspValid = (i % 2 == 0); imemRspData = 32'hDEAD_BEEF;
      branchTaken = 1'b1; branchTarget = 64'h200;
      cyc();
    end
    idle_inputs();
    instrReady = 1'b1; cyc(); instrReady = 1'b0;
    compared++;
    if (imemReq !== 1'b1 || imemAddr !== 64'h8 || instrValid !== 1'b0) begin
      mismatched++;
      $display("FAIL hold_ignore_branch: req=%b addr=%h valid=%b expected 1/8/0", imemReq, imemAddr, instrValid);
    end
  endtask

  task automatic test_branch();
    imemGrant = 1'b1; cyc(); imemGrant = 1'b0;
    imemRspValid = 1'b1; imemRspData = 32'h0000_0063; cyc(); imemRspValid = 1'b0;
    instrReady = 1'b1; branchTaken = 1'b1; branchTarget = 64'h100; cyc();
    idle_inputs();
    compared++;
    if (imemReq !== 1'b1 || imemAddr !== 64'h100) begin
      mismatched++;
      $display("FAIL branch_redirect: req=%b addr=%h expected 1/100", imemReq, imemAddr);
    end
  endtask

  task automatic test_misalign();
    imemGrant = 1'b1; cyc(); imemGrant = 1'b0;
    imemRspValid = 1'b1; imemRspData = 32'h0000_0063; cyc(); imemRspValid = 1'b0;
    instrReady = 1'b1; branchTaken = 1'b1; branchTarget = 64'h102; cyc();
    idle_inputs();
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (fetchFault !== 1'b1 || imemReq !== 1'b0 || instrValid !== 1'b0) begin
        mismatched++;
        $display("FAIL misalign_fault[%0d]: fault=%b req=%b valid=%b expected 1/0/0",
                 i, fetchFault, imemReq, instrValid);
      end
      imemGrant = 1'b1; imemRspValid = 1'b1; instrReady = 1'b1; cyc();
    end
    idle_inputs();
    resetN = 1'b0; cyc();
    compared++;
    if (fetchFault !== 1'b0) begin
      mismatched++;
      $display("FAIL misalign_reset: fault=%b expected 0", fetchFault);
    end
    resetN = 1'b1; cyc();
    compared++;
    if (imemReq !== 1'b1 || imemAddr !== 64'h0) begin
      mismatched++;
      $display("FAIL misalign_recover: req=%b addr=%h expected 1/0", imemReq, imemAddr);
    end
`else
    compared++;
    if (imemReq !== 1'b1 || imemAddr !== 64'h100 || fetchFault !== 1'b0) begin
      mismatched++;
      $display("FAIL misalign_align: req=%b addr=%h fault=%b expected 1/100/0", imemReq, imemAddr, fetchFault);
    end
`endif
  endtask

  task automatic test_random();
    logic [63:0] model_pc;
    logic [63:0] tgt;
    logic [31:0] data;
    logic        br;
    int          w;
    idle_inputs();
    resetN = 1'b0; cyc(); cyc(); resetN = 1'b1;
    model_pc = 64'h0;
    for (int t = 0; t < 40; t++) begin
      w = 0;
      while (imemReq !== 1'b1 && w < 8) begin cyc(); w++; end
      compared++;
      if (imemReq !== 1'b1 || imemAddr !== model_pc) begin
        mismatched++;
        $display("FAIL rand_req[%0d]: req=%b addr=%h expected 1/%h", t, imemReq, imemAddr, model_pc);
      end
      for (int s = int'($urandom_range(0, 3)); s > 0; s--) begin
        imemRspValid = $urandom_range(0, 1) == 1; imemRspData = $urandom;
        cyc();
        compared++;
        if (imemReq !== 1'b1 || imemAddr !== model_pc) begin
          mismatched++;
          $display("FAIL rand_stall[%0d]: req=%b addr=%h expected 1/%h", t, imemReq, imemAddr, model_pc);
        end
      end
      imemRspValid = 1'b0;
      imemGrant = 1'b1; cyc(); imemGrant = 1'b0;
      for (int s = int'($urandom_range(0, 3)); s > 0; s--) begin
        cyc();
        compared++;
        if (imemReq !== 1'b0 || instrValid !== 1'b0) begin
          mismatched++;
          $display("FAIL rand_wait[%0d]: req=%b valid=%b expected 0/0", t, imemReq, instrValid);
        end
      end
      data = $urandom;
      imemRspValid = 1'b1; imemRspData = data; cyc(); imemRspValid = 1'b0;
      for (int s = int'($urandom_range(0, 3)); s >= 0; s--) begin
        compared++;
        if (instrValid !== 1'b1 || instruction !== data || opcode !== data[6:0] ||
            instrPc !== model_pc || imemReq !== 1'b0) begin
          mismatched++;
          $display("FAIL rand_hold[%0d]: valid=%b instr=%h op=%h pc=%h req=%b expected 1/%h/%h/%h/0",
                   t, instrValid, instruction, opcode, instrPc, imemReq, data, data[6:0], model_pc);
        end
        if (s > 0) begin
          branchTaken = $urandom_range(0, 1) == 1; branchTarget = {$urandom, $urandom};
          imemRspValid = $urandom_range(0, 1) == 1; imemRspData = $urandom;
          cyc();
        end
      end
      br  = $urandom_range(0, 1) == 1;
      tgt = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt = tgt & ~64'h3;
`endif
      imemRspValid = 1'b0;
      instrReady = 1'b1; branchTaken = br; branchTarget = tgt; cyc();
      idle_inputs();
      model_pc = br ? (tgt & ~64'h3) : model_pc + 64'h4;
      compared++;
      if (instrValid !== 1'b0 || fetchFault !== 1'b0) begin
        mismatched++;
        $display("FAIL rand_consume[%0d]: valid=%b fault=%b expected 0/0", t, instrValid, fetchFault);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_grant_stall();
    test_hold();
    test_branch();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
